// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: walks a pattern ROM address window at a prescaled rate and holds each fetched pattern on the LEDs.
// Optional ping-pong mode via `define LED_SEQ_BOUNCE_EN; without it the address wraps at the window ends.
module led_pattern_sequencer #(
    parameter int unsigned PRESCALE = 50000000,
    parameter logic [11:0] LO_ADDR  = 12'd0,
    parameter logic [11:0] HI_ADDR  = 12'd4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        step,
    input  logic        dir,
    output logic        rom_en,
    output logic [11:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic [3:0]  led,
    output logic        frame_tick
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        FETCH   = 3'b010,
        CAPTURE = 3'b100
    } state_t;

    localparam logic [31:0] PRESC_LAST = 32'(PRESCALE - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] presc_cnt;
    logic        tick;
    logic [11:0] addr_nxt;

    assign tick = run && (presc_cnt == PRESC_LAST);

    // Dropping run clears the count so the next run starts a full period.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (!run || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults assigned first so no path through the case leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run ? tick : step) state_nxt = FETCH;
            FETCH:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Driven straight from the single IDLE flop of the one-hot code, so it cannot glitch.
    assign rom_en = ~state[0];

`ifdef LED_SEQ_BOUNCE_EN
    logic bounce;
    logic bounce_nxt;
    logic eff_dir;

    always_comb begin
        eff_dir    = dir ^ bounce;
        bounce_nxt = bounce;
        addr_nxt   = rom_addr;
        if (!eff_dir) begin
            if (rom_addr == HI_ADDR) begin
                addr_nxt   = HI_ADDR - 12'd1;
                bounce_nxt = ~bounce;
            end else begin
                addr_nxt = rom_addr + 12'd1;
            end
        end else begin
            if (rom_addr == LO_ADDR) begin
                addr_nxt   = LO_ADDR + 12'd1;
                bounce_nxt = ~bounce;
            end else begin
                addr_nxt = rom_addr - 12'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bounce <= 1'b0;
        end else if (state == CAPTURE) begin
            bounce <= bounce_nxt;
        end
    end
`else
    always_comb begin
        addr_nxt = rom_addr;
        if (!dir) begin
            addr_nxt = (rom_addr == HI_ADDR) ? LO_ADDR : rom_addr + 12'd1;
        end else begin
            addr_nxt = (rom_addr == LO_ADDR) ? HI_ADDR : rom_addr - 12'd1;
        end
    end
`endif

    // Address only moves on CAPTURE->IDLE, keeping it stable for the whole read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= LO_ADDR;
            led        <= 4'h0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (state == CAPTURE);
            if (state == CAPTURE) begin
                led      <= rom_data;
                rom_addr <= addr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with a 1-cycle pattern ROM model (data = addr[3:0]).
// Expected sequences follow LED_SEQ_BOUNCE_EN when it is defined.
module tb_led_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic        dir;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [3:0]  rom_data;
    logic [3:0]  led;
    logic        frame_tick;
    logic [3:0]  rom_q = 4'h0;

    int checks = 0;
    int errors = 0;

`ifdef LED_SEQ_BOUNCE_EN
    logic [11:0] auto_addr [4] = '{12'd1, 12'd2, 12'd3, 12'd2};
    logic [11:0] walk_addr [8] = '{12'd1, 12'd2, 12'd3, 12'd2, 12'd1, 12'd0, 12'd1, 12'd2};
    logic [11:0] third_step_addr = 12'd2;
    logic [3:0]  first_down_led  = 4'd2;
`else
    logic [11:0] auto_addr [4] = '{12'd1, 12'd2, 12'd3, 12'd0};
    logic [11:0] walk_addr [8] = '{12'd1, 12'd2, 12'd3, 12'd0, 12'd1, 12'd2, 12'd3, 12'd0};
    logic [11:0] third_step_addr = 12'd0;
    logic [3:0]  first_down_led  = 4'd0;
`endif

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .PRESCALE(4),
        .LO_ADDR (12'd0),
        .HI_ADDR (12'd3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .step      (step),
        .dir       (dir),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .led       (led),
        .frame_tick(frame_tick)
    );

    always_ff @(posedge clk) begin
        if (rom_en) rom_q <= rom_addr[3:0];
    end
    assign rom_data = rom_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, " led"}, 32'(led), 32'd0);
        check({tag, " rom_en"}, 32'(rom_en), 32'd0);
        check({tag, " frame_tick"}, 32'(frame_tick), 32'd0);
    endtask

    // One manual advance from IDLE; checks the 2-cycle enable and the update at T+3.
    task automatic do_step(input string tag, input logic [3:0] exp_led, input logic [11:0] exp_addr);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check({tag, " fetch rom_en"}, 32'(rom_en), 32'd1);
        cyc();
        check({tag, " capture rom_en"}, 32'(rom_en), 32'd1);
        check({tag, " early frame_tick"}, 32'(frame_tick), 32'd0);
        cyc();
        check({tag, " frame_tick"}, 32'(frame_tick), 32'd1);
        check({tag, " led"}, 32'(led), 32'(exp_led));
        check({tag, " rom_addr"}, 32'(exp_addr) ^ 32'(rom_addr) ^ 32'(exp_addr), 32'(exp_addr));
        check({tag, " rom_en off"}, 32'(rom_en), 32'd0);
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra;
        logic [11:0] prev_addr;

        rst_n = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        dir   = 1'b0;
        repeat (3) cyc();
        check_reset_outputs("reset");

        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("idle after reset rom_en", 32'(rom_en), 32'd0);
        end

        // Automatic ascending: tick on 4th run cycle, frame_tick 3 cycles later, period 4.
        run = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            cyc();
            check("auto rom_en", 32'(rom_en), 32'(k >= 4 && (k % 4 == 0 || k % 4 == 1)));
            check("auto frame_tick", 32'(frame_tick), 32'(k >= 6 && (k - 6) % 4 == 0));
            if (k >= 6 && (k - 6) % 4 == 0) begin
                check("auto led", 32'(led), 32'((k - 6) / 4));
                check("auto rom_addr", 32'(rom_addr), 32'(auto_addr[(k - 6) / 4]));
            end
        end

        // Asynchronous reset while a run fetch is in progress.
        cyc();
        cyc();
        check("run fetch rom_en", 32'(rom_en), 32'd1);
        check("run fetch led", 32'(led), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset mid-run");
        run = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (rom_en || frame_tick) extra++;
        end
        check("no activity after reset", 32'(extra), 32'd0);

        // Manual step with extra step requests in FETCH and CAPTURE: one advance only.
        step = 1'b1;
        cyc();
        check("manual fetch rom_en", 32'(rom_en), 32'd1);
        cyc();
        check("manual capture rom_en", 32'(rom_en), 32'd1);
        check("manual early frame_tick", 32'(frame_tick), 32'd0);
        step = 1'b0;
        cyc();
        check("manual frame_tick", 32'(frame_tick), 32'd1);
        check("manual led", 32'(led), 32'd0);
        check("manual rom_addr", 32'(rom_addr), 32'd1);
        check("manual rom_en off", 32'(rom_en), 32'd0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (rom_en || frame_tick) extra++;
        end
        check("step not queued", 32'(extra), 32'd0);

        do_step("step1", 4'd1, 12'd2);
        do_step("step2", 4'd2, 12'd3);
        do_step("step3 wrap", 4'd3, third_step_addr);

        dir = 1'b1;
        do_step("down1", first_down_led, 12'd3);
        do_step("down2", 4'd3, 12'd2);
        do_step("down3", 4'd2, 12'd1);

        // Reset during CAPTURE discards the pattern being fetched.
        step = 1'b1;
        cyc();
        step = 1'b0;
        cyc();
        check("abort capture rom_en", 32'(rom_en), 32'd1);
        check("abort pre led", 32'(led), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset mid-capture");
        cyc();
        cyc();
        rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (rom_en || frame_tick) extra++;
        end
        check("no tick after abort", 32'(extra), 32'd0);
        check("abort led held", 32'(led), 32'd0);
        check("abort rom_addr", 32'(rom_addr), 32'd0);

        // Window walk ascending through the top end.
        dir = 1'b0;
        prev_addr = 12'd0;
        for (int i = 0; i < 8; i++) begin
            do_step("walk", prev_addr[3:0], walk_addr[i]);
            prev_addr = walk_addr[i];
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
